// File: rtl/sync_up_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_up_pkg
//  Brief    : Shared constants for the sync_up synchronous up-counter.
//  Revision : 1.0  initial release
// ============================================================================
package sync_up_pkg;

  // Counter width used when the instantiating parent does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Supported width range for the counter.
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;

endpackage : sync_up_pkg
`default_nettype wire

// File: rtl/sync_up_t_ff.sv
`default_nettype none
// ============================================================================
//  Module   : t_ff
//  Brief    : Toggle flip-flop with synchronous active-high clear.
//             q inverts on each rising edge where t is high.
//  Revision : 1.0  initial release
// ============================================================================
module t_ff (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic r_q;

  // Clear has priority; otherwise toggle when enabled, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule : t_ff
`default_nettype wire

// File: rtl/sync_up.sv
`default_nettype none
// ============================================================================
//  Module   : sync_up
//  Brief    : Fully synchronous WIDTH-bit up-counter built from a chain of
//             toggle flip-flops sharing one clock. Bit i toggles when all
//             lower bits are 1; synchronous reset clears every bit.
//  Revision : 1.0  initial release
// ============================================================================
module sync_up
  import sync_up_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] counter
);

  // Toggle enables (AND chain) and flip-flop outputs.
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_q;

  // Bit 0 toggles on every non-reset edge.
  assign w_t[0] = 1'b1;

  // Carry-style enable chain: bit i toggles only when bits 0..i-1 are all 1.
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign w_t[gi] = w_t[gi-1] & w_q[gi-1];
    end
  endgenerate

  // One toggle flip-flop per counter bit, all on the common clock.
  generate
    for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
      t_ff u_t_ff (
        .clk (clk),
        .rst (rst),
        .t   (w_t[gb]),
        .q   (w_q[gb])
      );
    end
  endgenerate

  // Output comes straight from the flip-flops.
  assign counter = w_q;

`ifndef SYNTHESIS
  // Marks that at least one reset edge has been seen, so the increment
  // check never runs against the undefined power-up value.
  logic r_armed;

  // Arm the increment check on the first reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b1;
    end
  end

  a_reset_clears : assert property (@(posedge clk) rst |=> (counter == '0));

  a_increments : assert property (@(posedge clk)
      (!rst && (r_armed == 1'b1)) |=> (counter == WIDTH'($past(counter) + 1'b1)));
`endif

endmodule : sync_up
`default_nettype wire

// File: tb/tb_sync_up.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_up
//  Brief    : Self-checking bench for sync_up at WIDTH=4 and WIDTH=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_up;

  logic       clk  = 1'b0;
  logic       rst4 = 1'b1;
  logic       rst3 = 1'b1;
  logic [3:0] cnt4;
  logic [2:0] cnt3;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain integer count per instance, valid after reset.
  int m4 = 0;
  int m3 = 0;
  bit v4 = 1'b0;
  bit v3 = 1'b0;

  sync_up #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .rst     (rst4),
    .counter (cnt4)
  );

  sync_up #(.WIDTH(3)) u_dut3 (
    .clk     (clk),
    .rst     (rst3),
    .counter (cnt3)
  );

  // 100 ns period, first rising edge at 50 ns.
  initial forever #50 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge: reset to 0, else add one modulo 2^W.
  always @(posedge clk) begin
    if (rst4) begin
      m4 <= 0;
      v4 <= 1'b1;
    end else begin
      m4 <= (m4 + 1) % 16;
    end
    if (rst3) begin
      m3 <= 0;
      v3 <= 1'b1;
    end else begin
      m3 <= (m3 + 1) % 8;
    end
  end

  // Compare both instances against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (v4) chk("model_w4", int'(cnt4), m4);
    if (v3) chk("model_w3", int'(cnt3), m3);
  end

  // WIDTH=3 directed sequence: 9 edges after reset release -> 1..7,0,1.
  initial begin
    wait (rst3 == 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("w3_count", int'(cnt3), i % 8);
    end
  end

  // WIDTH=4 directed sequence.
  initial begin
    // Reset held for two edges.
    @(negedge clk);
    chk("reset_e1", int'(cnt4), 0);
    @(negedge clk);
    chk("reset_e2", int'(cnt4), 0);
    rst4 = 1'b0;
    rst3 = 1'b0;

    // Count 1..5.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("count", int'(cnt4), i);
    end

    // Wrap: return to 0, then 17 edges -> 1..15, 0, 1.
    rst4 = 1'b1;
    @(negedge clk);
    chk("wrap_start", int'(cnt4), 0);
    rst4 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk("wrap", int'(cnt4), k % 16);
    end

    // Mid-count reset at 9.
    repeat (8) @(negedge clk);
    chk("pre_mid", int'(cnt4), 9);
    rst4 = 1'b1;
    @(negedge clk);
    chk("mid_reset", int'(cnt4), 0);
    rst4 = 1'b0;
    @(negedge clk);
    chk("mid_release", int'(cnt4), 1);

    // Glitch immunity: 20 ns reset pulse between edges at 6.
    repeat (5) @(negedge clk);
    chk("pre_glitch", int'(cnt4), 6);
    #10 rst4 = 1'b1;
    #20 rst4 = 1'b0;
    chk("during_glitch", int'(cnt4), 6);
    @(negedge clk);
    chk("glitch", int'(cnt4), 7);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sync_up
`default_nettype wire
